// File: rtl/reg_scoreboard_pkg.sv
// Shared scoreboard sizing and a small helper that counts matching slots.
// Sizing defaults mirror the pipeline's register file (x0 is never tracked).
package reg_scoreboard_pkg;

    localparam int SB_RF_ADDR_WIDTH = 5;
    localparam int SB_NUM_REGS      = 32;
    localparam int SB_CNT_WIDTH     = 2;
    localparam int SB_BUSY_WIDTH    = 4;

    // Number of asserted hits among the two issue/writeback slots (0..2).
    function automatic logic [1:0] hit_count(input logic hit_a, input logic hit_b);
        return {1'b0, hit_a} + {1'b0, hit_b};
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// One register's outstanding long-latency write counter: net inc/dec per
// cycle, flush to zero, clamp at zero on stale writebacks, saturate at max.
module sb_entry
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_WIDTH = SB_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic [1:0]           inc_i,
    input  logic [1:0]           dec_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    localparam int SUM_WIDTH = CNT_WIDTH + 2;
    localparam logic [SUM_WIDTH-1:0] CNT_MAX = SUM_WIDTH'((1 << CNT_WIDTH) - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [SUM_WIDTH-1:0] raised;
    logic [SUM_WIDTH-1:0] dec_ext;
    logic [SUM_WIDTH-1:0] net;
    logic                 underflow;
    logic                 overflow;

    always_comb begin
        raised    = SUM_WIDTH'(cnt_q) + SUM_WIDTH'(inc_i);
        dec_ext   = SUM_WIDTH'(dec_i);
        underflow = raised < dec_ext;
        net       = underflow ? '0 : raised - dec_ext;
        overflow  = net > CNT_MAX;
        if (flush_i) begin
            cnt_d = '0;
        end else if (overflow) begin
            cnt_d = CNT_MAX[CNT_WIDTH-1:0];
        end else begin
            cnt_d = net[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

    // Underflow is expected after a flush squashes ops whose writeback still lands.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            assert (!overflow) else $error("sb_entry: counter incremented past maximum");
            assert (!underflow) else $warning("sb_entry: stale writeback clamped at zero");
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for long-latency destinations of the dual-issue pipe.
// Optional feature: define SB_WB_BYPASS_EN to release Busy in the writeback cycle.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int RF_ADDR_WIDTH = SB_RF_ADDR_WIDTH,
    parameter int NUM_REGS      = SB_NUM_REGS,
    parameter int CNT_WIDTH     = SB_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Issue_Valid_0,
    input  logic                     Issue_Valid_1,
    input  logic                     Issue_LongLat_0,
    input  logic                     Issue_LongLat_1,
    input  logic [RF_ADDR_WIDTH-1:0] Issue_RdAddr_0,
    input  logic [RF_ADDR_WIDTH-1:0] Issue_RdAddr_1,
    input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs1Addr_0,
    input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs2Addr_0,
    input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs1Addr_1,
    input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs2Addr_1,
    input  logic                     Wb_Valid_0,
    input  logic                     Wb_Valid_1,
    input  logic [RF_ADDR_WIDTH-1:0] Wb_RdAddr_0,
    input  logic [RF_ADDR_WIDTH-1:0] Wb_RdAddr_1,
    input  logic                     Flush,
    output logic [SB_BUSY_WIDTH-1:0] Scoreboard_Busy,
    output logic                     Scoreboard_StallReq,
    output logic                     Scoreboard_Full,
    output logic                     Scoreboard_Idle
);

    localparam int CMP_WIDTH = CNT_WIDTH + 2;
    localparam logic [CMP_WIDTH-1:0] CNT_MAX = CMP_WIDTH'((1 << CNT_WIDTH) - 1);

    logic [CNT_WIDTH-1:0]     cnt [NUM_REGS];
    logic [RF_ADDR_WIDTH-1:0] src_addr [SB_BUSY_WIDTH];
    logic [SB_BUSY_WIDTH-1:0] busy;
    logic [1:0]               cand_0;
    logic [1:0]               cand_1;
    logic                     full_0;
    logic                     full_1;
    logic                     idle;

    assign cnt[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
            localparam logic [RF_ADDR_WIDTH-1:0] REG_ADDR = RF_ADDR_WIDTH'(gi);
            logic [1:0] inc;
            logic [1:0] dec;

            assign inc = hit_count(Issue_Valid_0 & Issue_LongLat_0 & (Issue_RdAddr_0 == REG_ADDR),
                                   Issue_Valid_1 & Issue_LongLat_1 & (Issue_RdAddr_1 == REG_ADDR));
            assign dec = hit_count(Wb_Valid_0 & (Wb_RdAddr_0 == REG_ADDR),
                                   Wb_Valid_1 & (Wb_RdAddr_1 == REG_ADDR));

            sb_entry #(.CNT_WIDTH(CNT_WIDTH)) u_entry (
                .clk     (clk),
                .rst     (rst),
                .flush_i (Flush),
                .inc_i   (inc),
                .dec_i   (dec),
                .cnt_o   (cnt[gi])
            );
        end
    endgenerate

    assign src_addr[0] = Decode_Rs1Addr_0;
    assign src_addr[1] = Decode_Rs2Addr_0;
    assign src_addr[2] = Decode_Rs1Addr_1;
    assign src_addr[3] = Decode_Rs2Addr_1;

    generate
        for (gi = 0; gi < SB_BUSY_WIDTH; gi++) begin : g_src
            logic [CNT_WIDTH-1:0] src_cnt;
            logic                 pending;

            assign src_cnt = cnt[src_addr[gi]];
            assign pending = (src_addr[gi] != '0) && (src_cnt != '0);
`ifdef SB_WB_BYPASS_EN
            // Result is forwarded from the Wb path once every outstanding write lands now.
            logic [1:0] wb_hits;
            assign wb_hits = Flush ? 2'd0 :
                             hit_count(Wb_Valid_0 & (Wb_RdAddr_0 == src_addr[gi]),
                                       Wb_Valid_1 & (Wb_RdAddr_1 == src_addr[gi]));
            assign busy[gi] = pending && (CMP_WIDTH'(src_cnt) != CMP_WIDTH'(wb_hits));
`else
            assign busy[gi] = pending;
`endif
        end
    endgenerate

    // Full looks at the candidates in decode, independent of Valid, so issue can be held.
    assign cand_0 = hit_count(Issue_LongLat_0, Issue_LongLat_1 & (Issue_RdAddr_1 == Issue_RdAddr_0));
    assign cand_1 = hit_count(Issue_LongLat_1, Issue_LongLat_0 & (Issue_RdAddr_0 == Issue_RdAddr_1));
    assign full_0 = Issue_LongLat_0 && (Issue_RdAddr_0 != '0) &&
                    ((CMP_WIDTH'(cnt[Issue_RdAddr_0]) + CMP_WIDTH'(cand_0)) > CNT_MAX);
    assign full_1 = Issue_LongLat_1 && (Issue_RdAddr_1 != '0) &&
                    ((CMP_WIDTH'(cnt[Issue_RdAddr_1]) + CMP_WIDTH'(cand_1)) > CNT_MAX);

    always_comb begin
        idle = 1'b1;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (cnt[r] != '0) begin
                idle = 1'b0;
            end
        end
    end

    assign Scoreboard_Busy     = busy;
    assign Scoreboard_StallReq = |busy;
    assign Scoreboard_Full     = full_0 | full_1;
    assign Scoreboard_Idle     = idle;

    always_ff @(posedge clk) begin
        if (!rst && !Flush) begin
            assert (!(Issue_Valid_0 && full_0) && !(Issue_Valid_1 && full_1))
                else $error("reg_scoreboard: issue proceeded while Full");
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, hand-written
// reset sequence and randomized traffic against a counting reference model.
module tb_reg_scoreboard;

`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       iv0, iv1, il0, il1, wv0, wv1, flush;
    logic [4:0] ird0, ird1, rs1_0, rs2_0, rs1_1, rs2_1, wrd0, wrd1;
    logic [3:0] sb_busy;
    logic       sb_stall, sb_full, sb_idle;

    int n_checks = 0;
    int n_pass   = 0;
    int m_cnt [32];

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk                 (clk),
        .rst                 (rst),
        .Issue_Valid_0       (iv0),
        .Issue_Valid_1       (iv1),
        .Issue_LongLat_0     (il0),
        .Issue_LongLat_1     (il1),
        .Issue_RdAddr_0      (ird0),
        .Issue_RdAddr_1      (ird1),
        .Decode_Rs1Addr_0    (rs1_0),
        .Decode_Rs2Addr_0    (rs2_0),
        .Decode_Rs1Addr_1    (rs1_1),
        .Decode_Rs2Addr_1    (rs2_1),
        .Wb_Valid_0          (wv0),
        .Wb_Valid_1          (wv1),
        .Wb_RdAddr_0         (wrd0),
        .Wb_RdAddr_1         (wrd1),
        .Flush               (flush),
        .Scoreboard_Busy     (sb_busy),
        .Scoreboard_StallReq (sb_stall),
        .Scoreboard_Full     (sb_full),
        .Scoreboard_Idle     (sb_idle)
    );

    // is = {valid, longlat, rd}; src = {rs2_1, rs1_1, rs2_0, rs1_0}; w = {valid, rd}
    typedef struct {
        logic [6:0]  is0;
        logic [6:0]  is1;
        logic [19:0] src;
        logic [5:0]  w0;
        logic [5:0]  w1;
        logic        fl;
        logic [3:0]  busy;
        logic        full;
        logic        idle;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [6:0] is0, input logic [6:0] is1,
                                input logic [19:0] src, input logic [5:0] w0,
                                input logic [5:0] w1, input logic fl,
                                input logic [3:0] busy, input logic full, input logic idle);
        vec_t v;
        v.is0 = is0; v.is1 = is1; v.src = src; v.w0 = w0; v.w1 = w1;
        v.fl = fl; v.busy = busy; v.full = full; v.idle = idle;
        return v;
    endfunction

    function automatic int b2i(input logic b);
        return b ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_busy(input logic [4:0] a);
        int hits;
        if (a == 5'd0 || m_cnt[a] == 0) return 1'b0;
        hits = flush ? 0 : b2i(wv0 && wrd0 == a) + b2i(wv1 && wrd1 == a);
        if (BYP && m_cnt[a] == hits) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full_slot(input logic ll, input logic [4:0] rd);
        int want;
        if (!ll || rd == 5'd0) return 1'b0;
        want = b2i(il0 && ird0 == rd) + b2i(il1 && ird1 == rd);
        return (m_cnt[rd] + want) > 3;
    endfunction

    function automatic logic m_idle();
        for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_update();
        int v;
        for (int r = 1; r < 32; r++) begin
            if (flush) begin
                m_cnt[r] = 0;
            end else begin
                v = m_cnt[r]
                    + b2i(iv0 && il0 && int'(ird0) == r) + b2i(iv1 && il1 && int'(ird1) == r)
                    - b2i(wv0 && int'(wrd0) == r) - b2i(wv1 && int'(wrd1) == r);
                if (v < 0) v = 0;
                if (v > 3) v = 3;
                m_cnt[r] = v;
            end
        end
    endtask

    task automatic m_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    endtask

    task automatic check_model(input string tag);
        logic [3:0] eb;
        eb = {m_busy(rs2_1), m_busy(rs1_1), m_busy(rs2_0), m_busy(rs1_0)};
        chk({tag, " busy"}, sb_busy, eb);
        chk({tag, " stall"}, {3'b0, sb_stall}, {3'b0, |eb});
        chk({tag, " full"}, {3'b0, sb_full}, {3'b0, m_full_slot(il0, ird0) | m_full_slot(il1, ird1)});
        chk({tag, " idle"}, {3'b0, sb_idle}, {3'b0, m_idle()});
    endtask

    task automatic clear_inputs();
        {iv0, il0, ird0} = 7'd0;
        {iv1, il1, ird1} = 7'd0;
        {rs2_1, rs1_1, rs2_0, rs1_0} = 20'd0;
        {wv0, wrd0} = 6'd0;
        {wv1, wrd1} = 6'd0;
        flush = 1'b0;
    endtask

    // Called at posedge+1 with inputs held; advances to the next posedge+1.
    task automatic advance();
        @(posedge clk);
        m_update();
        #1;
    endtask

    initial begin
        vecs[0]  = mk({2'b11, 5'd5}, 7'd0, {15'd0, 5'd5}, 6'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[1]  = mk(7'd0, 7'd0, {15'd0, 5'd5}, 6'd0, 6'd0, 1'b0, 4'b0001, 1'b0, 1'b0);
        vecs[2]  = mk(7'd0, 7'd0, {15'd0, 5'd5}, 6'd0, 6'd0, 1'b0, 4'b0001, 1'b0, 1'b0);
        vecs[3]  = mk(7'd0, 7'd0, {15'd0, 5'd5}, {1'b1, 5'd5}, 6'd0, 1'b0,
                      BYP ? 4'b0000 : 4'b0001, 1'b0, 1'b0);
        vecs[4]  = mk(7'd0, 7'd0, {15'd0, 5'd5}, 6'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[5]  = mk({2'b11, 5'd7}, {2'b11, 5'd7}, {5'd7, 15'd0}, 6'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[6]  = mk(7'd0, 7'd0, {5'd7, 15'd0}, {1'b1, 5'd7}, 6'd0, 1'b0, 4'b1000, 1'b0, 1'b0);
        vecs[7]  = mk(7'd0, 7'd0, {5'd7, 15'd0}, 6'd0, {1'b1, 5'd7}, 1'b0,
                      BYP ? 4'b0000 : 4'b1000, 1'b0, 1'b0);
        vecs[8]  = mk(7'd0, 7'd0, {5'd7, 15'd0}, 6'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[9]  = mk({2'b11, 5'd9}, 7'd0, 20'd0, 6'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[10] = mk(7'd0, {2'b11, 5'd9}, 20'd0, {1'b1, 5'd9}, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
        vecs[11] = mk(7'd0, 7'd0, {5'd0, 5'd9, 10'd0}, 6'd0, 6'd0, 1'b0, 4'b0100, 1'b0, 1'b0);
        vecs[12] = mk(7'd0, 7'd0, 20'd0, 6'd0, {1'b1, 5'd9}, 1'b0, 4'b0000, 1'b0, 1'b0);
        vecs[13] = mk(7'd0, 7'd0, {5'd0, 5'd9, 10'd0}, 6'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[14] = mk({2'b11, 5'd3}, 7'd0, {15'd0, 5'd3}, 6'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[15] = mk({2'b11, 5'd3}, 7'd0, {15'd0, 5'd3}, 6'd0, 6'd0, 1'b0, 4'b0001, 1'b0, 1'b0);
        vecs[16] = mk({2'b11, 5'd3}, 7'd0, {15'd0, 5'd3}, 6'd0, 6'd0, 1'b0, 4'b0001, 1'b0, 1'b0);
        vecs[17] = mk({2'b01, 5'd3}, 7'd0, {15'd0, 5'd3}, 6'd0, 6'd0, 1'b0, 4'b0001, 1'b1, 1'b0);
        vecs[18] = mk(7'd0, {2'b01, 5'd3}, {10'd0, 5'd3, 5'd0}, 6'd0, 6'd0, 1'b0, 4'b0010, 1'b1, 1'b0);
        vecs[19] = mk(7'd0, 7'd0, {15'd0, 5'd3}, 6'd0, 6'd0, 1'b1, 4'b0001, 1'b0, 1'b0);
        vecs[20] = mk(7'd0, 7'd0, {15'd0, 5'd3}, {1'b1, 5'd3}, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[21] = mk(7'd0, 7'd0, {15'd0, 5'd3}, 6'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[22] = mk({2'b11, 5'd0}, {2'b11, 5'd0}, 20'd0, 6'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[23] = mk(7'd0, 7'd0, 20'd0, 6'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[24] = mk({2'b11, 5'd4}, 7'd0, 20'd0, 6'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[25] = mk({2'b11, 5'd4}, 7'd0, {15'd0, 5'd4}, 6'd0, 6'd0, 1'b0, 4'b0001, 1'b0, 1'b0);
        vecs[26] = mk({2'b01, 5'd4}, {2'b01, 5'd4}, {15'd0, 5'd4}, 6'd0, 6'd0, 1'b0, 4'b0001, 1'b1, 1'b0);
        vecs[27] = mk(7'd0, 7'd0, {15'd0, 5'd4}, {1'b1, 5'd4}, {1'b1, 5'd4}, 1'b0,
                      BYP ? 4'b0000 : 4'b0001, 1'b0, 1'b0);
        vecs[28] = mk(7'd0, 7'd0, {15'd0, 5'd4}, 6'd0, 6'd0, 1'b0, 4'b0000, 1'b0, 1'b1);

        // Reset state, with stimulus that would otherwise be active.
        m_reset();
        clear_inputs();
        rst = 1'b1;
        {iv0, il0, ird0} = {2'b11, 5'd6};
        rs1_0 = 5'd6;
        #12;
        chk("reset busy", sb_busy, 4'b0000);
        chk("reset stall", {3'b0, sb_stall}, 4'b0000);
        chk("reset full", {3'b0, sb_full}, 4'b0000);
        chk("reset idle", {3'b0, sb_idle}, 4'b0001);
        clear_inputs();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int i = 0; i < NVEC; i++) begin
            {iv0, il0, ird0} = vecs[i].is0;
            {iv1, il1, ird1} = vecs[i].is1;
            {rs2_1, rs1_1, rs2_0, rs1_0} = vecs[i].src;
            {wv0, wrd0} = vecs[i].w0;
            {wv1, wrd1} = vecs[i].w1;
            flush = vecs[i].fl;
            #2;
            chk($sformatf("vec%0d busy", i), sb_busy, vecs[i].busy);
            chk($sformatf("vec%0d stall", i), {3'b0, sb_stall}, {3'b0, |vecs[i].busy});
            chk($sformatf("vec%0d full", i), {3'b0, sb_full}, {3'b0, vecs[i].full});
            chk($sformatf("vec%0d idle", i), {3'b0, sb_idle}, {3'b0, vecs[i].idle});
            $display("vec%0d busy=%b stall=%b full=%b idle=%b", i, sb_busy, sb_stall, sb_full, sb_idle);
            advance();
        end

        // Randomized legal traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [4:0] r;
            clear_inputs();
            flush = ($urandom_range(0, 39) == 0);
            il0 = 1'($urandom_range(0, 1)); ird0 = 5'($urandom_range(0, 7)); iv0 = 1'($urandom_range(0, 1));
            il1 = 1'($urandom_range(0, 1)); ird1 = 5'($urandom_range(0, 7)); iv1 = 1'($urandom_range(0, 1));
            if (m_full_slot(il0, ird0)) iv0 = 1'b0;
            if (m_full_slot(il1, ird1)) iv1 = 1'b0;
            r = 5'($urandom_range(1, 7));
            if (m_cnt[r] > 0 && $urandom_range(0, 1) == 1) begin wv0 = 1'b1; wrd0 = r; end
            r = 5'($urandom_range(1, 7));
            if (m_cnt[r] > b2i(wv0 && wrd0 == r) && $urandom_range(0, 1) == 1) begin wv1 = 1'b1; wrd1 = r; end
            rs1_0 = 5'($urandom_range(0, 7)); rs2_0 = 5'($urandom_range(0, 7));
            rs1_1 = 5'($urandom_range(0, 7)); rs2_1 = 5'($urandom_range(0, 7));
            #2;
            check_model($sformatf("rnd%0d", c));
            $display("rnd%0d iss=%b%b wb=%b%b fl=%b busy=%b full=%b idle=%b",
                     c, iv0, iv1, wv0, wv1, flush, sb_busy, sb_full, sb_idle);
            advance();
        end

        // Asynchronous reset between clock edges while a register is pending.
        clear_inputs();
        #2;
        advance();
        {iv0, il0, ird0} = {2'b11, 5'd12};
        #2;
        advance();
        clear_inputs();
        rs1_0 = 5'd12;
        #2;
        check_model("pre-rst");
        #1 rst = 1'b1;
        #1;
        chk("midrst busy", sb_busy, 4'b0000);
        chk("midrst stall", {3'b0, sb_stall}, 4'b0000);
        chk("midrst idle", {3'b0, sb_idle}, 4'b0001);
        $display("midrst busy=%b stall=%b idle=%b", sb_busy, sb_stall, sb_idle);
        m_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        #3;
        chk("postrst busy", sb_busy, 4'b0000);
        chk("postrst idle", {3'b0, sb_idle}, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Per-register pending-write scoreboard for the dual-issue pipeline, the producer-side counterpart to decode-stage operand forwarding. It records destination registers of issued long-latency instructions (loads, mul/div) whose results cannot be forwarded from EX. It answers decode source-operand queries with busy flags and a stall request, and releases entries when writeback retires the result.

## Interface
- RF_ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, architectural registers tracked; x0 never tracked
- CNT_WIDTH, 2, per-register outstanding-write counter width (max 3 in flight)

Ports:
- clk  in  1  single pipeline clock
- rst  in  1  reset, asynchronous, active-high
- Issue_Valid_0 / Issue_Valid_1  in  1  slot 0/1 leaves decode this cycle (not stalled, not flushed)
- Issue_LongLat_0 / Issue_LongLat_1  in  1  slot result is long-latency (load, mul, div)
- Issue_RdAddr_0 / Issue_RdAddr_1  in  RF_ADDR_WIDTH  slot destination
- Decode_Rs1Addr_0, Decode_Rs2Addr_0, Decode_Rs1Addr_1, Decode_Rs2Addr_1  in  RF_ADDR_WIDTH  sources being decoded; 0 = unused
- Wb_Valid_0 / Wb_Valid_1  in  1  long-latency result written to RF this cycle
- Wb_RdAddr_0 / Wb_RdAddr_1  in  RF_ADDR_WIDTH  retired destination
- Flush  in  1  pipeline kill; all in-flight long-latency ops are squashed
- Scoreboard_Busy  out  4  {rs2_1, rs1_1, rs2_0, rs1_0} pending flags
- Scoreboard_StallReq  out  1  OR of Scoreboard_Busy
- Scoreboard_Full  out  1  an issuing destination's counter is at max
- Scoreboard_Idle  out  1  all counters zero (fence/CSR gating)

## Operation
- Per register r (1..NUM_REGS-1): counter cnt[r], reset 0.
- Next cnt[r] = cnt[r] + inc[r] - dec[r]; inc = count of issue slots with Valid & LongLat & RdAddr==r (0..2); dec = count of Wb slots with Valid & RdAddr==r (0..2).
- Both slots issuing same r: +2. Issue and Wb of same r in same cycle: net change applied.
- Decrement below 0 clamps to 0 (stale Wb after Flush); flagged by simulation assertion.
- Increment beyond max is illegal; Scoreboard_Full asserts combinationally when cnt[Issue_RdAddr_x] + inc would exceed max, and the pipeline must hold issue. Assertion fires if issue proceeds while Full.
- Flush: all counters to 0 next cycle; issue/Wb inputs in the Flush cycle ignored.
- Busy[i] = source addr != 0 and cnt[addr] != 0 (modified by bypass, see Configuration).
- Intra-pair RAW (slot 1 reads slot 0 long-latency rd) is not handled here; decode serialises the pair.
- Reset values: Busy 0, StallReq 0, Full 0, Idle 1.

## Timing
- Issue in cycle t -> cnt updated at edge t+1 -> Busy visible in t+1.
- Wb in cycle t -> cnt decremented at edge t+1.
- Busy/StallReq/Full/Idle are combinational from registered state and current-cycle inputs; no added latency.
- Reset asserted mid-operation clears all counters immediately; outputs return to reset values without waiting for clk.

## Configuration
- SB_WB_BYPASS_EN defined: Busy[i] is cleared in the Wb cycle when cnt[addr] equals the number of same-cycle Wb hits on addr (result forwarded from the Wb data path); stall releases in cycle t.
- Undefined: Busy reflects registered counters only; stall releases in cycle t+1.

## Structure
- Shared Define.v additions: SB_CNT_WIDTH, SB_NUM_REGS, SB_BUSY_WIDTH (4).
- One sub-module, sb_entry: single register's counter with inc/dec/flush/clamp logic; instantiated NUM_REGS-1 times by generate.

## Test plan
- Issue slot0 load rd=5 at t; decode rs1_0=5 at t+1 -> Busy=4'b0001, StallReq=1; Wb rd=5 at t+3 -> StallReq 0 in t+3 (bypass) or t+4 (no bypass).
- Both slots issue long-latency rd=7 same cycle -> cnt[7]=2; one Wb rd=7 -> still busy; second Wb -> clear.
- Issue rd=9 and Wb rd=9 same cycle with cnt[9]=1 -> cnt[9] stays 1, Busy for rs=9 remains 1.
- Three issues to rd=3 filling cnt to 3; fourth attempt -> Full=1 that cycle.
- Counters nonzero, Flush -> next cycle Idle=1; subsequent Wb rd=3 leaves cnt 0, assertion flagged.
- rst asserted mid-run between clock edges -> Busy=0, Idle=1 immediately; source rs=0 never busy.
